fir_mac_sequencer: RTL and testbench

//  Time-multiplexed FIR controller: one signed MAC (acc + coef*x) is reused over

---
 rtl/fir_mac_sequencer.sv | 123 ++++++++++++
 tb/tb_fir_mac_sequencer.sv | 226 ++++++++++++++++++++++
 2 files changed

// File: rtl/fir_mac_sequencer.sv
// Time-multiplexed FIR filter: a single signed MAC is stepped over all taps for
// every accepted sample, then the result is held until the sink takes it.
module fir_mac_sequencer #(
    parameter int in_WIDTH      = 8,
    parameter int filter_LENGTH = 8,
    parameter int counter_size  = $clog2(filter_LENGTH),
    parameter int out_WIDTH     = in_WIDTH * 2 + counter_size + 1
) (
    input  logic                    clk,
    input  logic                    rst_n,
    input  logic                    coef_we,
    input  logic [counter_size-1:0] coef_addr,
    input  logic [in_WIDTH-1:0]     coef_data,
    input  logic                    clear_hist,
    input  logic                    in_valid,
    input  logic [in_WIDTH-1:0]     in_data,
    output logic                    in_ready,
    output logic                    out_valid,
    output logic [out_WIDTH-1:0]    out_data,
    input  logic                    out_ready,
    output logic                    busy,
    output logic [1:0]              dbg_state
);

    localparam logic [1:0] S_IDLE = 2'd0;
    localparam logic [1:0] S_MAC  = 2'd1;
    localparam logic [1:0] S_DONE = 2'd2;
    localparam logic [counter_size-1:0] LAST_TAP = counter_size'(filter_LENGTH - 1);

    // Handshakes: a transfer happens on a rising edge where valid && ready are both
    // high; valid never waits on ready, and a raised out_valid holds with stable data.
    logic [1:0]                  state_q, state_d;
    logic [counter_size-1:0]     tap_q, tap_d;
    logic signed [out_WIDTH-1:0] acc_q, acc_d;
    logic [out_WIDTH-1:0]        out_data_q, out_data_d;
    logic                        out_valid_q, out_valid_d;
    logic signed [in_WIDTH-1:0]  coef_q [filter_LENGTH];
    logic signed [in_WIDTH-1:0]  coef_d [filter_LENGTH];
    logic signed [in_WIDTH-1:0]  x_q    [filter_LENGTH];
    logic signed [in_WIDTH-1:0]  x_d    [filter_LENGTH];

    logic signed [2*in_WIDTH-1:0] prod;
    logic signed [out_WIDTH-1:0]  acc_sum;
    logic                         accept;

    assign in_ready  = rst_n && (state_q == S_IDLE);
    assign accept    = in_valid && in_ready;
    assign out_valid = out_valid_q;
    assign out_data  = out_data_q;
    assign busy      = (state_q != S_IDLE);
    assign dbg_state = state_q;

    // Operands are sign-extended to the full product width before multiplying.
    assign prod    = (2*in_WIDTH)'(coef_q[tap_q]) * (2*in_WIDTH)'(x_q[tap_q]);
    assign acc_sum = acc_q + out_WIDTH'(prod);

    always_comb begin
        state_d     = state_q;
        tap_d       = tap_q;
        acc_d       = acc_q;
        out_data_d  = out_data_q;
        out_valid_d = out_valid_q;
        coef_d      = coef_q;
        x_d         = x_q;
        case (state_q)
            S_IDLE: begin
                for (int k = 0; k < filter_LENGTH; k++) begin
                    if (coef_we && coef_addr == counter_size'(k)) coef_d[k] = coef_data;
                    if (clear_hist) x_d[k] = '0;
                end
                if (accept) begin
                    x_d[0] = in_data;
                    for (int k = 1; k < filter_LENGTH; k++) begin
                        x_d[k] = clear_hist ? '0 : x_q[k-1];
                    end
                    acc_d   = '0;
                    tap_d   = '0;
                    state_d = S_MAC;
                end
            end
            S_MAC: begin
                acc_d = acc_sum;
                tap_d = tap_q + 1'b1;
                if (tap_q == LAST_TAP) begin
                    out_data_d  = acc_sum;
                    out_valid_d = 1'b1;
                    tap_d       = '0;
                    state_d     = S_DONE;
                end
            end
            S_DONE: begin
                if (out_ready) begin
                    out_valid_d = 1'b0;
                    state_d     = S_IDLE;
                end
            end
            default: state_d = S_IDLE;
        endcase
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q     <= S_IDLE;
            tap_q       <= '0;
            acc_q       <= '0;
            out_data_q  <= '0;
            out_valid_q <= 1'b0;
            for (int k = 0; k < filter_LENGTH; k++) begin
                coef_q[k] <= '0;
                x_q[k]    <= '0;
            end
        end else begin
            state_q     <= state_d;
            tap_q       <= tap_d;
            acc_q       <= acc_d;
            out_data_q  <= out_data_d;
            out_valid_q <= out_valid_d;
            coef_q      <= coef_d;
            x_q         <= x_d;
        end
    end

endmodule

// File: tb/tb_fir_mac_sequencer.sv
// Directed bench for fir_mac_sequencer with hand-computed expected outputs.
module tb_fir_mac_sequencer;

    logic        clk = 1'b0;
    logic        rst_n;
    logic        coef_we;
    logic [2:0]  coef_addr;
    logic [7:0]  coef_data;
    logic        clear_hist;
    logic        in_valid;
    logic [7:0]  in_data;
    logic        in_ready;
    logic        out_valid;
    logic [19:0] out_data;
    logic        out_ready;
    logic        busy;
    logic [1:0]  dbg_state;

    int n_checks = 0;
    int n_pass   = 0;
    logic [31:0] exp_q[$];

    fir_mac_sequencer dut (
        .clk(clk), .rst_n(rst_n),
        .coef_we(coef_we), .coef_addr(coef_addr), .coef_data(coef_data),
        .clear_hist(clear_hist),
        .in_valid(in_valid), .in_data(in_data), .in_ready(in_ready),
        .out_valid(out_valid), .out_data(out_data), .out_ready(out_ready),
        .busy(busy), .dbg_state(dbg_state)
    );

    // clock / reset
    always #5 clk = ~clk;

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic check(input string tag, input logic signed [31:0] got,
                         input logic signed [31:0] exp);
        n_checks++;
        if (got === exp) n_pass++;
        else $display("FAIL %s: got %0d expected %0d", tag, got, exp);
    endtask

    // driver tasks
    task automatic write_coef(input int addr, input int data);
        coef_we   = 1'b1;
        coef_addr = addr[2:0];
        coef_data = data[7:0];
        tick();
        coef_we   = 1'b0;
    endtask

    task automatic set_all_coefs(input int v);
        for (int k = 0; k < 8; k++) write_coef(k, v);
    endtask

    task automatic clear();
        clear_hist = 1'b1;
        tick();
        clear_hist = 1'b0;
    endtask

    task automatic send(input int d);
        int n;
        n = 0;
        in_valid = 1'b1;
        in_data  = d[7:0];
        while (!in_ready && n < 200) begin
            tick();
            n++;
        end
        if (!in_ready) check("accept_timeout", 0, 1);
        tick();
        in_valid = 1'b0;
    endtask

    // scoreboard: waits for out_valid, checks latency and data, completes handshake
    task automatic get_result(input string tag, input int lat_exp);
        int cyc;
        logic signed [31:0] e;
        cyc = 0;
        while (!out_valid && cyc < 50) begin
            tick();
            cyc++;
        end
        e = (exp_q.size() > 0) ? $signed(exp_q.pop_front()) : 32'sd0;
        check({tag, "_lat"}, cyc, lat_exp);
        check({tag, "_data"}, $signed(out_data), e);
        if (out_ready) tick();
    endtask

    initial begin
        logic ok;
        rst_n = 1'b0; coef_we = 1'b0; coef_addr = '0; coef_data = '0;
        clear_hist = 1'b0; in_valid = 1'b0; in_data = '0; out_ready = 1'b1;
        repeat (3) tick();
        check("rst_out_valid", out_valid, 0);
        check("rst_busy", busy, 0);
        check("rst_out_data", $signed(out_data), 0);
        check("rst_in_ready", in_ready, 0);
        rst_n = 1'b1;
        #1;
        check("rel_in_ready", in_ready, 1);
        tick();

        // impulse response with coef[k] = k+1
        for (int k = 0; k < 8; k++) write_coef(k, k + 1);
        for (int i = 0; i < 8; i++) begin
            exp_q.push_back(i + 1);
            send(i == 0 ? 1 : 0);
            get_result("impulse", 8);
        end
        check("idle_after_hs", in_ready, 1);

        // extremes: n-th output with a cleared history is n*16384
        set_all_coefs(-128);
        clear();
        for (int i = 1; i <= 8; i++) begin
            exp_q.push_back(i * 16384);
            send(-128);
            get_result("ext_neg", 8);
        end
        set_all_coefs(127);
        for (int i = 0; i < 8; i++) begin
            exp_q.push_back(-130048);
            send(-128);
            get_result("ext_mix", 8);
        end

        // backpressure with a sample held on in_valid
        out_ready = 1'b0;
        exp_q.push_back(-113665);
        send(1);
        in_valid = 1'b1;
        in_data  = 8'd2;
        get_result("bp", 8);
        ok = 1'b1;
        for (int i = 0; i < 5; i++) begin
            tick();
            if (!(out_valid && $signed(out_data) == -113665 && !in_ready && busy)) ok = 1'b0;
        end
        check("bp_hold", ok, 1);
        out_ready = 1'b1;
        tick();
        check("bp_valid_drop", out_valid, 0);
        check("bp_ready_back", in_ready, 1);
        tick();
        in_valid = 1'b0;
        check("bp_accept", busy, 1);
        exp_q.push_back(-97155);
        get_result("bp_next", 8);
        check("out_data_kept", $signed(out_data), -97155);

        // coefficient write during MAC is ignored
        set_all_coefs(1);
        clear();
        exp_q.push_back(3);
        send(3);
        tick();
        tick();
        write_coef(0, 50);
        get_result("mac_wr", 5);
        exp_q.push_back(4);
        send(1);
        get_result("mac_wr_next", 8);
        write_coef(0, 50);
        exp_q.push_back(54);
        send(1);
        get_result("idle_wr", 8);

        // same-edge coef write and sample accept
        set_all_coefs(0);
        clear();
        coef_we = 1'b1; coef_addr = 3'd0; coef_data = 8'd3;
        in_valid = 1'b1; in_data = 8'd2;
        tick();
        coef_we = 1'b0;
        in_valid = 1'b0;
        exp_q.push_back(6);
        get_result("same_edge", 8);

        // clear_hist alone, then together with an accept
        set_all_coefs(1);
        clear();
        exp_q.push_back(5);
        send(5);
        get_result("clear", 8);
        clear_hist = 1'b1;
        exp_q.push_back(1);
        send(1);
        clear_hist = 1'b0;
        get_result("clear_same", 8);

        // reset in the middle of a computation
        send(7);
        repeat (4) tick();
        rst_n = 1'b0;
        #1;
        check("mid_rst_busy", busy, 0);
        check("mid_rst_valid", out_valid, 0);
        check("mid_rst_data", $signed(out_data), 0);
        check("mid_rst_state", dbg_state, 0);
        ok = 1'b1;
        for (int i = 0; i < 10; i++) begin
            tick();
            if (out_valid) ok = 1'b0;
        end
        rst_n = 1'b1;
        #1;
        check("mid_rst_no_valid", ok, 1);
        check("mid_rst_ready", in_ready, 1);
        tick();
        for (int i = 0; i < 8; i++) begin
            exp_q.push_back(0);
            send(i == 0 ? 1 : 0);
            get_result("post_rst", 8);
        end

        $display("%0d/%0d checks passed", n_pass, n_checks);
        $finish;
    end

endmodule
